// File: rtl/demodulador_fsk_if.sv
// rtl/demodulador_fsk_if.sv - sample-in / bit-out bundle of the FSK demodulator
// Signals:
//   amostra        [7:0]  unsigned input sample
//   amostra_valida        qualifies amostra this cycle
//   sinc                  symbol-start marker, meaningful with amostra_valida
//   dado                  last decided bit, held between decisions
//   dado_valido           one-cycle pulse: new dado/soma available
//   soma          [12:0]  accumulated sum of the last completed symbol
//   indice         [4:0]  index the next accepted sample will occupy
// master = sample source / bit consumer, slave = demodulator.
interface demodulador_fsk_if;
    logic [7:0]  amostra;
    logic        amostra_valida;
    logic        sinc;
    logic        dado;
    logic        dado_valido;
    logic [12:0] soma;
    logic [4:0]  indice;

    modport master (
        output amostra, amostra_valida, sinc,
        input  dado, dado_valido, soma, indice
    );

    modport slave (
        input  amostra, amostra_valida, sinc,
        output dado, dado_valido, soma, indice
    );
endinterface

// File: rtl/demodulador_fsk.sv
// rtl/demodulador_fsk.sv - FSK bit recovery from 32-sample symbols by summed |delta|
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high
//   bus_if  demodulador_fsk_if.slave (samples in, decided bits out)
// Parameters:
//   LIMIAR            decision threshold, bit = 1 when symbol sum > LIMIAR
//   SINC_OBRIGATORIO  1 = drop samples after reset until the first sinc
module demodulador_fsk #(
    parameter int LIMIAR           = 636,
    parameter bit SINC_OBRIGATORIO = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    demodulador_fsk_if.slave bus_if
);

    typedef enum logic {
        AGUARDA,
        ACUMULA
    } estado_t;

    localparam estado_t     ESTADO_INICIAL = SINC_OBRIGATORIO ? AGUARDA : ACUMULA;
    localparam logic [12:0] LIMIAR_SOMA    = 13'(LIMIAR);
    localparam logic [7:0]  MEIA_ESCALA    = 8'd128;

    estado_t     estado_q;
    logic [7:0]  anterior_q;
    logic [12:0] acc_q;
    logic [4:0]  indice_q;
    logic        dado_q;
    logic        dado_valido_q;
    logic [12:0] soma_q;

    logic        aceita;
    logic [4:0]  indice_ef;
    logic [7:0]  dif;
    logic [12:0] acc_d;

    always_comb begin
        // In AGUARDA only the sinc-marked sample gets through.
        aceita    = bus_if.amostra_valida && (estado_q == ACUMULA || bus_if.sinc);
        // A sinc sample always restarts the symbol at index 0.
        indice_ef = bus_if.sinc ? 5'd0 : indice_q;
        dif       = (bus_if.amostra >= anterior_q) ? (bus_if.amostra - anterior_q)
                                                   : (anterior_q - bus_if.amostra);
        acc_d     = (indice_ef == 5'd0) ? {5'd0, dif} : (acc_q + {5'd0, dif});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= ESTADO_INICIAL;
            anterior_q    <= MEIA_ESCALA;
            acc_q         <= 13'd0;
            indice_q      <= 5'd0;
            dado_q        <= 1'b0;
            dado_valido_q <= 1'b0;
            soma_q        <= 13'd0;
        end else begin
            dado_valido_q <= 1'b0;
            if (aceita) begin
                estado_q   <= ACUMULA;
                // anterior survives a sinc so the boundary difference is counted.
                anterior_q <= bus_if.amostra;
                indice_q   <= indice_ef + 5'd1;
                if (indice_ef == 5'd31) begin
                    soma_q        <= acc_d;
                    dado_q        <= (acc_d > LIMIAR_SOMA);
                    dado_valido_q <= 1'b1;
                    acc_q         <= 13'd0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign bus_if.dado        = dado_q;
    assign bus_if.dado_valido = dado_valido_q;
    assign bus_if.soma        = soma_q;
    assign bus_if.indice      = indice_q;

endmodule

// File: tb/tb_demodulador_fsk.sv
// tb/tb_demodulador_fsk.sv - self-checking bench for demodulador_fsk
// Two instances: one free-running (SINC_OBRIGATORIO=0), one needing sinc (=1).
// Stimulus is steered to the instance chosen by sel; a queue-based model of the
// symbol sums predicts every output each cycle.
module tb_demodulador_fsk;

    localparam int LIMIAR = 636;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] am  = 8'd0;
    logic       av  = 1'b0;
    logic       sc  = 1'b0;
    logic       sel = 1'b0;

    demodulador_fsk_if if_livre ();
    demodulador_fsk_if if_sinc ();

    assign if_livre.amostra        = am;
    assign if_livre.amostra_valida = av & ~sel;
    assign if_livre.sinc           = sc;
    assign if_sinc.amostra         = am;
    assign if_sinc.amostra_valida  = av & sel;
    assign if_sinc.sinc            = sc;

    demodulador_fsk #(.LIMIAR(LIMIAR), .SINC_OBRIGATORIO(1'b0)) dut_livre (
        .clock  (clock),
        .reset  (reset),
        .bus_if (if_livre)
    );

    demodulador_fsk #(.LIMIAR(LIMIAR), .SINC_OBRIGATORIO(1'b1)) dut_sinc (
        .clock  (clock),
        .reset  (reset),
        .bus_if (if_sinc)
    );

    // {dado_valido, indice, dado, soma}
    logic [19:0] obs_livre, obs_sinc, obs;
    assign obs_livre = {if_livre.dado_valido, if_livre.indice, if_livre.dado, if_livre.soma};
    assign obs_sinc  = {if_sinc.dado_valido, if_sinc.indice, if_sinc.dado, if_sinc.soma};
    assign obs       = sel ? obs_sinc : obs_livre;

    // Generator output for one symbol: bit 0 = one sine cycle, bit 1 = 1.5 cycles.
    logic [7:0] tab0 [32] = '{
        8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
        8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
        8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
        8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103};
    logic [7:0] tab1 [32] = '{
        8'd128, 8'd165, 8'd199, 8'd227, 8'd246, 8'd255, 8'd254, 8'd241,
        8'd219, 8'd188, 8'd153, 8'd115, 8'd79,  8'd47,  8'd22,  8'd6,
        8'd0,   8'd6,   8'd22,  8'd47,  8'd79,  8'd115, 8'd153, 8'd188,
        8'd219, 8'd241, 8'd254, 8'd255, 8'd246, 8'd227, 8'd199, 8'd165};

    // Reference model: differences of the current symbol kept in a queue.
    int          m_prev;
    int          m_sym[$];
    int          m_soma;
    bit          m_dado;
    bit          m_waiting;
    logic [19:0] exp_v;

    // Pulses observed on the active instance.
    logic        got_dado[$];
    logic [12:0] got_soma[$];

    int errors = 0;
    int checks = 0;

    function automatic string fmt(input logic [19:0] v);
        return $sformatf("dv=%0b idx=%0d dado=%0b soma=%0d", v[19], v[18:14], v[13], v[12:0]);
    endfunction

    function automatic logic [7:0] amostra_tab(input bit b, input int n);
        return b ? tab1[n] : tab0[n];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        am    = 8'($urandom);
        av    = 1'b1;
        sc    = 1'($urandom);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        av        = 1'b0;
        sc        = 1'b0;
        m_prev    = 128;
        m_sym.delete();
        m_soma    = 0;
        m_dado    = 1'b0;
        m_waiting = sel;
        exp_v     = 20'd0;
        got_dado.delete();
        got_soma.delete();
    endtask

    // Drives one cycle, advances the model and records any pulse seen.
    task automatic step(input logic [7:0] s, input bit v, input bit sy);
        int tot;
        int si;
        bit pulse;
        am = s;
        av = v;
        sc = sy;
        @(posedge clock);
        #1;
        pulse = 1'b0;
        si    = int'(s);
        if (v && (!m_waiting || sy)) begin
            m_waiting = 1'b0;
            if (sy) m_sym.delete();
            m_sym.push_back(si > m_prev ? si - m_prev : m_prev - si);
            m_prev = si;
            if (m_sym.size() == 32) begin
                tot = 0;
                foreach (m_sym[i]) tot += m_sym[i];
                m_soma = tot;
                m_dado = (tot > LIMIAR);
                pulse  = 1'b1;
                m_sym.delete();
            end
        end
        exp_v = {pulse, 5'(m_sym.size()), m_dado, 13'(m_soma)};
        if (obs[19]) begin
            got_dado.push_back(obs[13]);
            got_soma.push_back(obs[12:0]);
        end
        av = 1'b0;
        sc = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        checks++;
        if (obs_livre !== 20'd0) begin
            errors++;
            $display("FAIL reset_livre got %s want all zero", fmt(obs_livre));
        end
        checks++;
        if (obs_sinc !== 20'd0) begin
            errors++;
            $display("FAIL reset_sinc got %s want all zero", fmt(obs_sinc));
        end
    endtask

    task automatic test_symbol_table(input bit b, input int want_soma);
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 32; n++) begin
            step(amostra_tab(b, n), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL table%0d n=%0d got %s want %s", b, n, fmt(obs), fmt(exp_v));
            end
        end
        step(8'd0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL table%0d_after got %s want %s", b, fmt(obs), fmt(exp_v));
        end
        checks++;
        if (got_soma.size() != 1 || got_soma[0] !== 13'(want_soma) || got_dado[0] !== b) begin
            errors++;
            $display("FAIL table%0d_pulse got pulses=%0d first=(%0b,%0d) want one pulse (%0b,%0d)",
                     b, got_soma.size(), got_dado.size() > 0 ? got_dado[0] : 1'bx,
                     got_soma.size() > 0 ? got_soma[0] : 13'bx, b, want_soma);
        end
    endtask

    task automatic test_sequence_gaps();
        bit          bits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int          want [4] = '{483, 752, 764, 520};
        bit          gap;
        sel = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 32; n++) begin
                while ($urandom_range(0, 2) == 0) begin
                    step(8'($urandom), 1'b0, 1'($urandom));
                    checks++;
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL seq_gap sym=%0d n=%0d got %s want %s", k, n, fmt(obs), fmt(exp_v));
                    end
                end
                step(amostra_tab(bits[k], n), 1'b1, 1'b0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL seq sym=%0d n=%0d got %s want %s", k, n, fmt(obs), fmt(exp_v));
                end
            end
        end
        gap = 1'b0;
        checks++;
        if (got_soma.size() != 4) begin
            errors++;
            gap = 1'b1;
            $display("FAIL seq_count got %0d pulses want 4", got_soma.size());
        end
        if (!gap) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_dado[k] !== bits[k] || got_soma[k] !== 13'(want[k])) begin
                    errors++;
                    $display("FAIL seq_pulse k=%0d got (%0b,%0d) want (%0b,%0d)",
                             k, got_dado[k], got_soma[k], bits[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_sinc_mid();
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 32; n++) step(tab0[n], 1'b1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            step(tab1[n], 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sinc_mid_pre n=%0d got %s want %s", n, fmt(obs), fmt(exp_v));
            end
        end
        step(tab1[10], 1'b1, 1'b1);
        checks++;
        if (obs[19:14] !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL sinc_mid_idx got dv=%0b idx=%0d want dv=0 idx=1", obs[19], obs[18:14]);
        end
        for (int n = 1; n < 32; n++) begin
            step(8'($urandom), 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sinc_mid_post n=%0d got %s want %s", n, fmt(obs), fmt(exp_v));
            end
        end
        checks++;
        if (obs[19] !== 1'b1 || got_soma.size() != 2) begin
            errors++;
            $display("FAIL sinc_mid_pulse got dv=%0b pulses=%0d want dv=1 pulses=2", obs[19], got_soma.size());
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        do_reset();
        for (int n = 0; n < 32; n++) step(tab1[n], 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) step(tab1[n], 1'b1, 1'b0);
        checks++;
        if (obs !== {1'b0, 5'd20, 1'b1, 13'd727}) begin
            errors++;
            $display("FAIL reset_mid_before got %s want dv=0 idx=20 dado=1 soma=727", fmt(obs));
        end
        do_reset();
        checks++;
        if (obs !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid_cleared got %s want all zero", fmt(obs));
        end
        for (int n = 0; n < 32; n++) begin
            step(tab1[n], 1'b1, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_sym n=%0d got %s want %s", n, fmt(obs), fmt(exp_v));
            end
        end
        checks++;
        if (obs !== {1'b1, 5'd0, 1'b1, 13'd727}) begin
            errors++;
            $display("FAIL reset_mid_pulse got %s want dv=1 idx=0 dado=1 soma=727", fmt(obs));
        end
    endtask

    task automatic test_sinc_required();
        sel = 1'b1;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            step(8'($urandom), 1'b1, 1'b0);
            checks++;
            if (obs !== 20'd0) begin
                errors++;
                $display("FAIL sinc_req_drop n=%0d got %s want all zero", n, fmt(obs));
            end
        end
        for (int n = 0; n < 32; n++) begin
            step(tab0[n], 1'b1, n == 0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sinc_req_sym n=%0d got %s want %s", n, fmt(obs), fmt(exp_v));
            end
        end
        checks++;
        if (obs !== {1'b1, 5'd0, 1'b0, 13'd483}) begin
            errors++;
            $display("FAIL sinc_req_pulse got %s want dv=1 idx=0 dado=0 soma=483", fmt(obs));
        end
        sel = 1'b0;
    endtask

    // Sums of exactly LIMIAR and LIMIAR+1: 30 steps of 20 then a last step of 36/37.
    task automatic test_limiar();
        logic [7:0] ultimo;
        sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            ultimo = 8'(164 + k);
            for (int n = 0; n < 32; n++) begin
                step(n == 31 ? ultimo : ((n % 2) == 1 ? 8'd148 : 8'd128), 1'b1, 1'b0);
            end
            checks++;
            if (obs !== {1'b1, 5'd0, 1'(k), 13'(636 + k)}) begin
                errors++;
                $display("FAIL limiar k=%0d got %s want dv=1 idx=0 dado=%0d soma=%0d",
                         k, fmt(obs), k, 636 + k);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            do_reset();
            for (int n = 0; n < 500; n++) begin
                step(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL random sel=%0d n=%0d got %s want %s", s, n, fmt(obs), fmt(exp_v));
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_symbol_table(1'b0, 483);
        test_symbol_table(1'b1, 727);
        test_sequence_gaps();
        test_sinc_mid();
        test_reset_mid();
        test_sinc_required();
        test_limiar();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/demodulador_fsk.md
# demodulador_fsk

Receive-side counterpart of the sine-table FSK generator. It consumes the 8-bit unsigned sample stream that the generator produces (32 samples per symbol; bit 0 = one sine cycle, bit 1 = 1.5 cycles, both starting at midscale 128) and recovers one data bit per symbol. The bit decision is made by accumulating the absolute sample-to-sample difference over a symbol window and comparing the sum against a threshold. It sits between the sample source (ADC or loopback from the generator) and the bit-level consumer.

## Interface
- LIMIAR, 636, decision threshold; decided bit = 1 when the symbol sum > LIMIAR, otherwise 0.
- SINC_OBRIGATORIO, 0, 1 = ignore samples after reset until the first `sinc`; 0 = start accumulating immediately.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- amostra  in  8  unsigned input sample.
- amostra_valida  in  1  qualifies `amostra` for this cycle.
- sinc  in  1  symbol-start marker; meaningful only when `amostra_valida`=1.
- dado  out  1  last decided bit; held between decisions.
- dado_valido  out  1  one-cycle pulse: new `dado`/`soma` available.
- soma  out  13  accumulated sum of the last completed symbol.
- indice  out  5  index that the next accepted sample will occupy (0..31).

## Operation
- Registers: `anterior` (8b, previous accepted sample), `acc` (13b), `indice` (5b), FSM state.
- FSM states: AGUARDA, ACUMULA.
  - Reset -> AGUARDA if SINC_OBRIGATORIO=1, else ACUMULA.
  - AGUARDA: accepted samples without `sinc` are dropped (no register changes); valid+`sinc` -> ACUMULA, processing that sample as index 0.
  - ACUMULA: stays until reset.
- Per accepted sample (`amostra_valida`=1, in ACUMULA or the `sinc` sample leaving AGUARDA):
  - d = |amostra − anterior|, 8-bit unsigned result (max 255).
  - At index 0: acc ← d; at other indices: acc ← acc + d. The sum cannot exceed 32×255 = 8160, so 13 bits never overflow.
  - anterior ← amostra; indice ← indice + 1, wrapping 31 -> 0.
  - At index 31: soma ← acc + d; dado ← (acc + d > LIMIAR); dado_valido ← 1; acc ← 0.
- `sinc` with a valid sample in ACUMULA: that sample becomes index 0. Any partial sum is discarded without a decision. `anterior` is not cleared, so the boundary difference still counts.
- `sinc` without `amostra_valida`: ignored.
- `amostra_valida`=0: every register holds, except that `dado_valido` returns to 0.
- Expected sums for generator output: bit 0 = 483 plus the boundary difference; bit 1 = 727 plus the boundary difference. The boundary difference is 0 after reset, 25 after a 0, and 37 after a 1.

## Timing
- Reset values: dado=0, dado_valido=0, soma=0, indice=0, acc=0, anterior=128, state per SINC_OBRIGATORIO.
- Latency: the index-31 sample is presented in cycle N. `dado`, `soma` and `dado_valido`=1 are visible in cycle N+1, and `dado_valido` is 0 in cycle N+2.
- One sample is accepted per cycle; back-to-back symbols need no gap cycle.
- Reset asserted mid-symbol: the partial symbol is abandoned, no pulse is produced, and all registers take their reset values on that edge.
- Sum exactly equal to LIMIAR decides 0.

## Test plan
- Reset, then the 32-sample bit-0 table back-to-back -> a single `dado_valido` pulse one cycle after the 32nd sample, with dado=0 and soma=483.
- Reset, then the 32-sample bit-1 table -> dado=1, soma=727.
- Symbols 0,1,1,0 streamed with random `amostra_valida` gaps -> four pulses in order: (0,483), (1,752), (1,764), (0,520). No pulse occurs during gap cycles.
- `sinc` on the 11th sample of a symbol -> no pulse for the partial symbol. The next pulse follows 32 accepted samples counted from the `sinc` sample, and `indice` reads 1 after the `sinc` sample.
- Reset asserted at index 20 -> outputs and `indice` return to their reset values. The next full bit-1 symbol gives soma=727.
- SINC_OBRIGATORIO=1: 40 samples without `sinc` -> `indice` stays 0 and no pulse occurs. A `sinc` followed by a bit-0 symbol -> dado=0, soma=483.
